angle_sweep_gen: RTL and testbench

Parametrised fixed-point angle sweep generator that feeds the cordic core. It is the successor to the free-running 1-degree angle counter in the board top level. It adds:
- selectable sweep modes (wrap, bounce, single-shot);
- exact modular wrap;
- quadrant tagging;
- a valid/ready handshake, so a slow or pipelined consumer never misses or duplicates an angle.

It sits between the board clock domain and the cordic angle input.

---
 rtl/cordic_pkg.sv | 26 ++
 rtl/tick_divider.sv | 46 ++++
 rtl/angle_sweep_gen.sv | 166 ++++++++++++++++
 tb/tb_angle_sweep_gen.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and encodings for the cordic front end.
// The angle constants are Q.10 fixed point, matching the cordic core's angle input.
package cordic_pkg;

   localparam int FP_SHIFT      = 10;
   localparam int STEP_1DEG     = 18;     // round(pi/180 * 1024)
   localparam int TWO_PI        = 6434;   // round(2*pi * 1024)
   localparam int HALF_PI       = 1608;
   localparam int PI            = 3217;
   localparam int THREE_HALF_PI = 4825;

   typedef enum logic [1:0] {
      MODE_WRAP   = 2'd0,
      MODE_BOUNCE = 2'd1,
      MODE_SINGLE = 2'd2,
      MODE_RSVD   = 2'd3
   } sweep_mode_e;

   typedef enum logic [1:0] {
      QUAD_0 = 2'd0,
      QUAD_1 = 2'd1,
      QUAD_2 = 2'd2,
      QUAD_3 = 2'd3
   } quadrant_e;

endpackage

// File: rtl/tick_divider.sv
// Sweep prescaler: counts 0..DIV-1 while run is high and raises tick on the last count.
// While hold is high the counter parks on the last count so the pending tick is not lost.
module tick_divider #(
   parameter int DIV = 131072
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic hold,
   output logic tick
);

   localparam int             PCW     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PCW-1:0] PC_LAST = PCW'(DIV - 1);

   logic [PCW-1:0] pc_q;
   logic [PCW-1:0] pc_d;

   assign tick = run && (pc_q == PC_LAST);

   // NOTE: pc_d gets its default before any branch so no path leaves it unassigned (no latch).
   always_comb begin
      pc_d = pc_q;
      if (run) begin
         if (tick) begin
            pc_d = hold ? PC_LAST : '0;
         end else begin
            pc_d = pc_q + 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   // With DIV=1 tick would fire on every enabled cycle and the stall parking could not work.
   a_div_legal: assert property (@(posedge clk) DIV >= 2)
      else $error("tick_divider: DIV must be at least 2");

endmodule

// File: rtl/angle_sweep_gen.sv
// Fixed-point angle sweep generator feeding the cordic angle input, with wrap, bounce and
// single-shot sweeps, quadrant tagging and a valid/ready handshake toward the consumer.
module angle_sweep_gen
   import cordic_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int FPSHIFT = FP_SHIFT,
   parameter int DIV     = 131072,
   parameter int STEP    = STEP_1DEG,
   parameter int LIMIT   = TWO_PI
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             clear,
   input  logic [1:0]       mode,
   input  logic             out_ready,
   output logic [WIDTH-1:0] angle,
   output logic [1:0]       quadrant,
   output logic             out_valid,
   output logic             dir,
   output logic             done,
   output logic             stalled
);

   // One extra bit of headroom so angle+STEP and 2*MAXA never overflow.
   localparam logic [WIDTH:0]   STEP_W  = (WIDTH + 1)'(STEP);
   localparam logic [WIDTH:0]   LIMIT_W = (WIDTH + 1)'(LIMIT);
   localparam logic [WIDTH:0]   MAXA_W  = (WIDTH + 1)'(LIMIT - 1);
   localparam logic [WIDTH:0]   MAXA2_W = (WIDTH + 1)'(2 * (LIMIT - 1));
   localparam logic [WIDTH-1:0] QH_W    = WIDTH'(HALF_PI);
   localparam logic [WIDTH-1:0] QP_W    = WIDTH'(PI);
   localparam logic [WIDTH-1:0] Q3_W    = WIDTH'(THREE_HALF_PI);

   logic [WIDTH-1:0] angle_q,   angle_d;
   logic             dir_q,     dir_d;
   logic             done_q,    done_d;
   logic             valid_q,   valid_d;
   logic             stalled_q, stalled_d;

   logic             tick;
   logic             hold;
   logic             step;
   logic [WIDTH:0]   angle_x;
   logic [WIDTH:0]   sum_x;
   logic [WIDTH:0]   next_x;
   logic             next_dir;
   logic             next_done;

   // Once single-shot has finished, ticks are ignored, so the prescaler must keep cycling.
   assign hold = valid_q && !out_ready && !done_q;
   assign step = tick && !hold && !done_q;

   tick_divider #(
      .DIV (DIV)
   ) u_tick_divider (
      .clk   (clk),
      .rst_n (rst_n && !clear),
      .run   (run),
      .hold  (hold),
      .tick  (tick)
   );

   assign angle_x = {1'b0, angle_q};
   assign sum_x   = angle_x + STEP_W;

   always_comb begin
      next_x    = sum_x;
      next_dir  = 1'b0;
      next_done = done_q;
      case (mode)
         MODE_BOUNCE: begin
            if (!dir_q) begin
               if (sum_x > MAXA_W) begin
                  next_x   = MAXA2_W - sum_x;
                  next_dir = 1'b1;
               end
            end else if (angle_x < STEP_W) begin
               next_x = STEP_W - angle_x;
            end else begin
               next_x   = angle_x - STEP_W;
               next_dir = 1'b1;
            end
         end
         MODE_SINGLE: begin
            if (sum_x > MAXA_W) begin
               next_x    = MAXA_W;
               next_done = 1'b1;
            end
         end
         default: begin
            if (sum_x >= LIMIT_W) begin
               next_x = sum_x - LIMIT_W;
            end
         end
      endcase
   end

   // With run low, tick and step are both low, so only the handshake clear can act.
   always_comb begin
      angle_d   = angle_q;
      dir_d     = dir_q;
      done_d    = done_q;
      valid_d   = valid_q;
      stalled_d = stalled_q;
      if (clear) begin
         angle_d   = '0;
         dir_d     = 1'b0;
         done_d    = 1'b0;
         valid_d   = 1'b0;
         stalled_d = 1'b0;
      end else begin
         if (out_ready) begin
            valid_d = 1'b0;
         end
         if (step) begin
            angle_d = next_x[WIDTH-1:0];
            dir_d   = next_dir;
            done_d  = next_done;
            valid_d = 1'b1;
         end
         if (tick) begin
            stalled_d = hold;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         angle_q   <= '0;
         dir_q     <= 1'b0;
         done_q    <= 1'b0;
         valid_q   <= 1'b0;
         stalled_q <= 1'b0;
      end else begin
         angle_q   <= angle_d;
         dir_q     <= dir_d;
         done_q    <= done_d;
         valid_q   <= valid_d;
         stalled_q <= stalled_d;
      end
   end

   always_comb begin
      if (angle_q >= Q3_W) begin
         quadrant = QUAD_3;
      end else if (angle_q >= QP_W) begin
         quadrant = QUAD_2;
      end else if (angle_q >= QH_W) begin
         quadrant = QUAD_1;
      end else begin
         quadrant = QUAD_0;
      end
   end

   assign angle     = angle_q;
   assign out_valid = valid_q;
   assign dir       = dir_q;
   assign done      = done_q;
   assign stalled   = stalled_q;

   a_width_legal: assert property (@(posedge clk)
      (WIDTH > FPSHIFT) && ((longint'(2) * LIMIT) < (longint'(1) <<< (WIDTH - 1))))
      else $error("angle_sweep_gen: WIDTH too small for 2*LIMIT");

endmodule

// File: tb/tb_angle_sweep_gen.sv
// Bench for angle_sweep_gen: an arithmetic reference model checked every cycle, plus
// directed sweeps with hand-computed angles at the wrap, bounce and single-shot boundaries.
module tb_angle_sweep_gen;

   localparam int WIDTH = 32;
   localparam int DIV   = 4;
   localparam int STEP  = 18;
   localparam int LIMIT = 6434;
   localparam int MAXA  = LIMIT - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             run;
   logic             clear;
   logic [1:0]       mode;
   logic             out_ready;
   logic [WIDTH-1:0] angle;
   logic [1:0]       quadrant;
   logic             out_valid;
   logic             dir;
   logic             done;
   logic             stalled;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   angle_sweep_gen #(
      .WIDTH   (WIDTH),
      .FPSHIFT (10),
      .DIV     (DIV),
      .STEP    (STEP),
      .LIMIT   (LIMIT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .clear     (clear),
      .mode      (mode),
      .out_ready (out_ready),
      .angle     (angle),
      .quadrant  (quadrant),
      .out_valid (out_valid),
      .dir       (dir),
      .done      (done),
      .stalled   (stalled)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_angle;
   int m_pc;
   bit m_dir;
   bit m_done;
   bit m_valid;
   bit m_stalled;

   function automatic int quad_of(input int a);
      if (a >= 4825) return 3;
      if (a >= 3217) return 2;
      if (a >= 1608) return 1;
      return 0;
   endfunction

   task automatic m_step(input int md);
      int s;
      s = m_angle + STEP;
      if (md == 1) begin
         if (!m_dir) begin
            if (s <= MAXA) m_angle = s;
            else begin
               m_angle = MAXA - (s - MAXA);
               m_dir   = 1'b1;
            end
         end else if (m_angle >= STEP) begin
            m_angle = m_angle - STEP;
         end else begin
            m_angle = STEP - m_angle;
            m_dir   = 1'b0;
         end
      end else if (md == 2) begin
         m_dir = 1'b0;
         if (s > MAXA) begin
            m_angle = MAXA;
            m_done  = 1'b1;
         end else begin
            m_angle = s;
         end
      end else begin
         m_dir   = 1'b0;
         m_angle = s % LIMIT;
      end
      m_valid = 1'b1;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         if (!rst_n || clear) begin
            m_angle = 0; m_pc = 0; m_dir = 0; m_done = 0; m_valid = 0; m_stalled = 0;
         end else begin
            bit pending;
            bit at_end;
            pending = m_valid && !out_ready;
            at_end  = (m_pc == DIV - 1);
            if (out_ready) m_valid = 1'b0;
            if (run) begin
               if (at_end && pending && !m_done) begin
                  m_stalled = 1'b1;
               end else begin
                  m_pc = (m_pc + 1) % DIV;
                  if (at_end) begin
                     m_stalled = 1'b0;
                     if (!m_done) m_step(int'(mode));
                  end
               end
            end
         end
         #1;
         check("model_angle",    angle,     m_angle);
         check("model_quadrant", quadrant,  quad_of(m_angle));
         check("model_valid",    out_valid, m_valid);
         check("model_dir",      dir,       m_dir);
         check("model_done",     done,      m_done);
         check("model_stalled",  stalled,   m_stalled);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_angle(input int target, input int budget, input string name);
      int n;
      n = 0;
      while (!(out_valid && angle == target) && n < budget) begin
         cyc();
         n++;
      end
      check({name, "_reached"}, (out_valid && angle == target), 1);
   endtask

   task automatic wait_next(input string name);
      int n;
      n = 0;
      while (out_valid && n < 50) begin cyc(); n++; end
      while (!out_valid && n < 50) begin cyc(); n++; end
      check({name, "_seen"}, out_valid, 1);
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!out_valid && n < 20) begin cyc(); n++; end
      check({name, "_seen"}, out_valid, 1);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; run = 1'b0; clear = 1'b0; mode = 2'd0; out_ready = 1'b1;
      repeat (2) cyc();
      check("reset_angle",    angle,     0);
      check("reset_quadrant", quadrant,  0);
      check("reset_valid",    out_valid, 0);
      check("reset_dir",      dir,       0);
      check("reset_done",     done,      0);
      check("reset_stalled",  stalled,   0);

      // First step four clocks after release; reserved mode sweeps like wrap.
      rst_n = 1'b1; run = 1'b1; mode = 2'd3;
      n = 0;
      do begin cyc(); n++; end while (!out_valid && n < 20);
      check("first_valid_clock", n, 4);
      check("first_angle",       angle, 18);
      check("first_quadrant",    quadrant, 0);
      wait_angle(1800, 1000, "a1800");
      check("a1800_quadrant", quadrant, 1);

      // Wrap keeps the remainder: 6426+18-6434 = 10.
      mode = 2'd0;
      wait_angle(6426, 2000, "wrap_top");
      check("wrap_top_quadrant", quadrant, 3);
      wait_next("wrap");
      check("wrap_angle",    angle,    10);
      check("wrap_quadrant", quadrant, 0);
      check("wrap_dir",      dir,      0);

      // Bounce: top reflection 2*6433-6444 = 6422, bottom reflection 18-14 = 4.
      clear = 1'b1; mode = 2'd1;
      cyc();
      clear = 1'b0;
      check("clear_angle", angle, 0);
      check("clear_valid", out_valid, 0);
      wait_angle(6426, 1600, "bounce_top");
      check("bounce_top_dir", dir, 0);
      wait_next("bounce_reflect");
      check("bounce_reflect_angle", angle, 6422);
      check("bounce_reflect_dir",   dir,   1);
      wait_angle(14, 1600, "bounce_low");
      check("bounce_low_dir", dir, 1);
      wait_next("bounce_bottom");
      check("bounce_bottom_angle", angle, 4);
      check("bounce_bottom_dir",   dir,   0);

      // Switching away from a descending bounce forces dir=0: 6422+18-6434 = 6.
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      wait_angle(6426, 1600, "bounce2_top");
      wait_next("bounce2_reflect");
      check("bounce2_dir", dir, 1);
      mode = 2'd3;
      wait_next("force_dir");
      check("force_dir_angle", angle, 6);
      check("force_dir_dir",   dir,   0);

      // Single-shot clamps at MAXA and then ignores ticks.
      clear = 1'b1; mode = 2'd2;
      cyc();
      clear = 1'b0;
      wait_angle(6426, 1600, "single_top");
      wait_next("single_end");
      check("single_end_angle",    angle,    6433);
      check("single_end_done",     done,     1);
      check("single_end_quadrant", quadrant, 3);
      cyc();
      n = 0;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (out_valid) n++;
      end
      check("single_no_valid", n, 0);
      check("single_held",     angle, 6433);
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      check("single_clear_angle", angle, 0);
      check("single_clear_done",  done,  0);

      // Backpressure: angle holds, stall from the next tick, no step lost on accept.
      mode = 2'd0; out_ready = 1'b0;
      wait_valid("bp_first");
      check("bp_first_angle", angle, 18);
      for (int i = 1; i <= 10; i++) begin
         cyc();
         if (i == 3) check("bp_not_yet_stalled", stalled, 0);
         if (i == 4) check("bp_stalled", stalled, 1);
      end
      check("bp_angle_held", angle, 18);
      check("bp_valid_held", out_valid, 1);
      out_ready = 1'b1;
      cyc();
      check("bp_release_angle",   angle,     36);
      check("bp_release_valid",   out_valid, 1);
      check("bp_release_stalled", stalled,   0);

      // run=0 freezes the sweep but still lets the consumer accept.
      out_ready = 1'b0; run = 1'b0;
      repeat (6) cyc();
      check("freeze_angle", angle, 36);
      check("freeze_valid", out_valid, 1);
      out_ready = 1'b1;
      cyc();
      check("freeze_accept_valid", out_valid, 0);
      check("freeze_accept_angle", angle, 36);

      // Reset mid-sweep while stalled.
      run = 1'b1; out_ready = 1'b0;
      wait_valid("pre_reset");
      check("pre_reset_angle", angle, 54);
      repeat (6) cyc();
      check("pre_reset_stalled", stalled, 1);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      check("mid_reset_angle",    angle,     0);
      check("mid_reset_quadrant", quadrant,  0);
      check("mid_reset_valid",    out_valid, 0);
      check("mid_reset_stalled",  stalled,   0);

      // clear together with out_ready.
      wait_valid("pre_clear");
      clear = 1'b1; out_ready = 1'b1;
      cyc();
      clear = 1'b0;
      check("clear_ready_valid", out_valid, 0);
      check("clear_ready_angle", angle,     0);

      // Mixed traffic; the model checks every cycle.
      for (int i = 0; i < 800; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         run       = ($urandom_range(0, 9) != 0);
         clear     = (i % 250 == 249);
         if (i % 60 == 0) mode = 2'($urandom_range(0, 3));
         cyc();
      end
      clear = 1'b0; run = 1'b1; out_ready = 1'b1;
      repeat (4) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
